// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for the skid pipeline stage
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;
   localparam int PIPE_CNT_W = 2;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready register stage whose handshake outputs come only from the state flop
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [PIPE_CNT_W-1:0] count
);
   pipe_state_t      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic             in_fire, out_fire;
   assign out_valid = state_q != EMPTY;
   assign in_ready  = state_q != FULL;
   assign out_data  = main_q;
   assign count     = state_q == FULL ? 2'd2 : state_q == BUSY ? 2'd1 : 2'd0;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // next state: flush squashes to EMPTY, otherwise advance on the handshakes
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               state_d = in_fire ? BUSY : EMPTY;
               main_d  = in_fire ? in_data : main_q;
            end
            BUSY: begin
               state_d = in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : BUSY;
               main_d  = in_fire && out_fire ? in_data : main_q;
               skid_d  = in_fire && !out_fire ? in_data : skid_q;
            end
            FULL: begin
               state_d = out_fire ? BUSY : FULL;
               main_d  = out_fire ? skid_q : main_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end
   // state and data flops, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random handshakes checked against a FIFO queue model
module tb_pipe_skid_reg;
   logic       clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [3:0] in_data = 0;
   logic       in_ready, out_valid;
   logic [3:0] out_data;
   logic [1:0] count;
   logic [3:0] q[$];
   int         vectors = 0, errs = 0;

   pipe_skid_reg #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("out_valid", 4'(out_valid), 4'(q.size() > 0));
      chk("in_ready", 4'(in_ready), 4'(q.size() < 2));
      chk("count", 4'(count), 4'(q.size()));
      if (q.size() > 0) chk("out_data", out_data, q[0]);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 4'(out_valid), 4'h0);
      chk({tag, "_count"}, 4'(count), 4'h0);
      chk({tag, "_out_data"}, out_data, 4'h0);
      chk({tag, "_in_ready"}, 4'(in_ready), 4'h1);
   endtask

   // one cycle: drive at negedge, check pre-edge outputs, advance the queue model across the edge
   task automatic step(input logic iv, input logic [3:0] id, input logic ordy, input logic fl);
      bit ifire, ofire;
      @(negedge clk);
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
      #1;
      chk_model();
      ifire = iv && q.size() < 2;
      ofire = ordy && q.size() > 0;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (ofire) void'(q.pop_front());
         if (ifire) q.push_back(id);
      end
   endtask

   initial begin
      rst = 1; in_valid = 1; in_data = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
      @(negedge clk);
      rst = 0; in_valid = 0;
      #1;
      chk_reset_vals("rst_release");
      // streaming with consumer always ready
      step(1, 4'hA, 1, 0);
      step(1, 4'hB, 1, 0);
      step(1, 4'hC, 1, 0);
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 1, 0);
      // backpressure then drain
      step(1, 4'hA, 0, 0);
      step(1, 4'hB, 0, 0);
      step(1, 4'h7, 0, 0);
      step(0, 4'h0, 0, 0);
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 0, 0);
      // simultaneous fire in BUSY
      step(1, 4'hA, 0, 0);
      step(1, 4'hB, 1, 0);
      step(0, 4'h0, 0, 0);
      step(0, 4'h0, 1, 0);
      // flush from FULL while offering C
      step(1, 4'hA, 0, 0);
      step(1, 4'hB, 0, 0);
      step(1, 4'hC, 0, 1);
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 1, 0);
      // async reset while FULL, observed before the next edge
      step(1, 4'h5, 0, 0);
      step(1, 4'h6, 0, 0);
      @(negedge clk);
      in_valid = 0; out_ready = 0;
      #1;
      chk_model();
      #1 rst = 1;
      #1;
      chk_reset_vals("async_rst");
      q.delete();
      @(negedge clk);
      rst = 0;
      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      step(0, 4'h0, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
